// File: rtl/uart_transceiver.sv
// uart_transceiver: 8N1 UART with a fixed baud rate set by CLKS_PER_BIT.
// One byte in flight per direction. The transmitter and receiver are fully
// independent and share only clk and reset.
module uart_transceiver #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       tx,
   input  logic [7:0] tx_byte,
   input  logic       tx_req,
   output logic       tx_busy,
   output logic       rx_ready,
   output logic [7:0] rx_byte,
   output logic       rx_ferr
);

   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   tx_state_t     tx_state, tx_state_n;
   logic [CW-1:0] tx_cnt, tx_cnt_n;
   logic [2:0]    tx_idx, tx_idx_n;
   logic [7:0]    tx_shift, tx_shift_n;
   logic          tx_n;
   logic          tx_busy_n;

   // TX next state: each state lasts one bit time; tx and tx_busy are
   // computed here and registered so the line never glitches.
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_idx_n   = tx_idx;
      tx_shift_n = tx_shift;
      tx_n       = tx;
      tx_busy_n  = tx_busy;
      case (tx_state)
         TX_IDLE: begin
            tx_n      = 1'b1;
            tx_busy_n = 1'b0;
            if (tx_req) begin
               tx_shift_n = tx_byte;
               tx_cnt_n   = '0;
               tx_n       = 1'b0;
               tx_busy_n  = 1'b1;
               tx_state_n = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt == FULL_M1) begin
               tx_cnt_n   = '0;
               tx_idx_n   = '0;
               tx_n       = tx_shift[0];
               tx_state_n = TX_DATA;
            end else begin
               tx_cnt_n = tx_cnt + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_cnt == FULL_M1) begin
               tx_cnt_n   = '0;
               tx_shift_n = {1'b1, tx_shift[7:1]};
               if (tx_idx == 3'd7) begin
                  tx_n       = 1'b1;
                  tx_state_n = TX_STOP;
               end else begin
                  tx_n     = tx_shift[1];
                  tx_idx_n = tx_idx + 3'd1;
               end
            end else begin
               tx_cnt_n = tx_cnt + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_cnt == FULL_M1) begin
               tx_cnt_n   = '0;
               tx_n       = 1'b1;
               tx_busy_n  = 1'b0;
               tx_state_n = TX_IDLE;
            end else begin
               tx_cnt_n = tx_cnt + 1'b1;
            end
         end
         default: begin
            tx_n       = 1'b1;
            tx_busy_n  = 1'b0;
            tx_state_n = TX_IDLE;
         end
      endcase
   end

   // TX control registers; reset returns the line to idle high at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_idx   <= tx_idx_n;
         tx       <= tx_n;
         tx_busy  <= tx_busy_n;
      end
   end

   // TX shift register holds the latched byte; it is only read after a load.
   always_ff @(posedge clk) begin
      tx_shift <= tx_shift_n;
   end

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   logic          rx_p0;
   logic          rx_s;
   rx_state_t     rx_state, rx_state_n;
   logic [CW-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]    rx_idx, rx_idx_n;
   logic [7:0]    rx_shift, rx_shift_n;
   logic [7:0]    rx_byte_n;
   logic          rx_ready_n;
   logic          rx_ferr_n;

   // Two-flop synchronizer for the asynchronous rx line; idles high.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_p0 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_s  <= rx_p0;
      end
   end

   // RX next state: half a bit to the start-bit centre, then whole bits;
   // the frame is accepted at the centre of the stop bit.
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_idx_n   = rx_idx;
      rx_shift_n = rx_shift;
      rx_byte_n  = rx_byte;
      rx_ready_n = 1'b0;
      rx_ferr_n  = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_cnt_n   = '0;
               rx_state_n = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt == HALF_M1) begin
               rx_cnt_n = '0;
               if (rx_s) begin
                  rx_state_n = RX_IDLE;
               end else begin
                  rx_idx_n   = '0;
                  rx_state_n = RX_DATA;
               end
            end else begin
               rx_cnt_n = rx_cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt == FULL_M1) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_s, rx_shift[7:1]};
               if (rx_idx == 3'd7) begin
                  rx_state_n = RX_STOP;
               end else begin
                  rx_idx_n = rx_idx + 3'd1;
               end
            end else begin
               rx_cnt_n = rx_cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt == FULL_M1) begin
               rx_cnt_n = '0;
               if (rx_s) begin
                  rx_byte_n  = rx_shift;
                  rx_ready_n = 1'b1;
                  rx_state_n = RX_IDLE;
               end else begin
                  rx_ferr_n  = 1'b1;
                  rx_state_n = RX_WAIT_IDLE;
               end
            end else begin
               rx_cnt_n = rx_cnt + 1'b1;
            end
         end
         RX_WAIT_IDLE: begin
            if (rx_s) begin
               rx_state_n = RX_IDLE;
            end
         end
         default: begin
            rx_state_n = RX_IDLE;
         end
      endcase
   end

   // RX control registers and outputs; pulses last exactly one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_byte  <= '0;
         rx_ready <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_idx   <= rx_idx_n;
         rx_byte  <= rx_byte_n;
         rx_ready <= rx_ready_n;
         rx_ferr  <= rx_ferr_n;
      end
   end

   // RX shift register collects data bits, LSB first.
   always_ff @(posedge clk) begin
      rx_shift <= rx_shift_n;
   end

endmodule
